// File: rtl/z_stage_pkg.sv
// Shared opcode constants, drain-state encoding and FIFO entry layout for the
// ALU result stage.
package z_stage_pkg;

    localparam int ENTRY_DATA_W = 64;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_ROR = 4'b1001;
    localparam logic [3:0] OP_ROL = 4'b1010;
    localparam logic [3:0] OP_MAX = 4'b1010;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BEAT_LO = 2'b01,
        BEAT_HI = 2'b10
    } drain_state_t;

    typedef struct packed {
        logic                    wide;
        logic [ENTRY_DATA_W-1:0] data;
    } entry_t;

    function automatic logic is_wide(input logic [3:0] op);
        return op == OP_MUL;
    endfunction

    function automatic logic is_valid_op(input logic [3:0] op);
        return op <= OP_MAX;
    endfunction

endpackage

// File: rtl/z_result_stage_fifo.sv
// Power-of-two synchronous FIFO; exposes the head and the entry behind it so the
// drain logic can preload the next beat without a bubble.
module result_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 65
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             head,
    output logic [W-1:0]             second,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign do_push = push && !full;
    assign do_pop  = pop && (count != {(PW+1){1'b0}});
    assign head    = mem[rd_ptr];
    assign second  = mem[rd_ptr + PW'(1)];

    // Storage array, written only on an accepted push.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; simultaneous push and pop keep count.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wr_ptr <= {PW{1'b0}};
            rd_ptr <= {PW{1'b0}};
            count  <= {(PW+1){1'b0}};
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/z_result_stage.sv
// ALU result buffer: decodes and queues results, drains them as 32-bit beats
// (LO then HI for MUL), and retires HI/LO and zero/negative flags.
module z_result_stage
    import z_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              op,
    input  logic [DATA_W-1:0]       alu_out,
    input  logic [2*DATA_W-1:0]     alu_out2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_is_hi,
    output logic                    out_last,
    output logic [DATA_W-1:0]       hi_q,
    output logic [DATA_W-1:0]       lo_q,
    output logic                    zero_flag,
    output logic                    neg_flag,
    output logic                    err,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    drain_state_t state;
    entry_t       push_entry;
    entry_t       head;
    entry_t       second;
    entry_t       next_head;
    logic         full;
    logic         op_ok;
    logic         accept;
    logic         push;
    logic         pop;
    logic         handshake;
    logic         more;

    result_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
        .clock  (clock),
        .clear  (clear),
        .push   (push),
        .pop    (pop),
        .wdata  (push_entry),
        .head   (head),
        .second (second),
        .count  (count),
        .full   (full)
    );

    assign in_ready = !full;

    // Decode, pop decision and the entry that becomes head after a pop.
    always_comb begin
        op_ok           = is_valid_op(op);
        accept          = in_valid && in_ready;
        push            = accept && op_ok;
        push_entry.wide = is_wide(op);
        if (push_entry.wide) begin
            push_entry.data = alu_out2;
        end else begin
            push_entry.data = {{DATA_W{1'b0}}, alu_out};
        end
        handshake = out_valid && out_ready;
        case (state)
            BEAT_LO: pop = handshake && !head.wide;
            BEAT_HI: pop = handshake;
            default: pop = 1'b0;
        endcase
        more = (count > CNT_W'(1)) || push;
        // With a single entry left, anything following it is the one being pushed now.
        if (count > CNT_W'(1)) begin
            next_head = second;
        end else begin
            next_head = push_entry;
        end
    end

    // Drain FSM with registered beat outputs, HI/LO and flag retirement.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= {DATA_W{1'b0}};
            out_is_hi <= 1'b0;
            out_last  <= 1'b0;
            hi_q      <= {DATA_W{1'b0}};
            lo_q      <= {DATA_W{1'b0}};
            zero_flag <= 1'b0;
            neg_flag  <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= accept && !op_ok;
            case (state)
                IDLE: begin
                    if (count != CNT_W'(0)) begin
                        state     <= BEAT_LO;
                        out_valid <= 1'b1;
                        out_data  <= head.data[DATA_W-1:0];
                        out_is_hi <= 1'b0;
                        out_last  <= !head.wide;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                BEAT_LO, BEAT_HI: begin
                    if (handshake && state == BEAT_LO && head.wide) begin
                        state     <= BEAT_HI;
                        out_data  <= head.data[2*DATA_W-1:DATA_W];
                        out_is_hi <= 1'b1;
                        out_last  <= 1'b1;
                    end else if (handshake) begin
                        if (state == BEAT_HI) begin
                            hi_q      <= head.data[2*DATA_W-1:DATA_W];
                            lo_q      <= head.data[DATA_W-1:0];
                            zero_flag <= (head.data == {(2*DATA_W){1'b0}});
                            neg_flag  <= head.data[2*DATA_W-1];
                        end else begin
                            zero_flag <= (head.data[DATA_W-1:0] == {DATA_W{1'b0}});
                            neg_flag  <= head.data[DATA_W-1];
                        end
                        if (more) begin
                            state     <= BEAT_LO;
                            out_valid <= 1'b1;
                            out_data  <= next_head.data[DATA_W-1:0];
                            out_is_hi <= 1'b0;
                            out_last  <= !next_head.wide;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_data  <= {DATA_W{1'b0}};
                            out_is_hi <= 1'b0;
                            out_last  <= 1'b0;
                        end
                    end else begin
                        state <= state;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z_result_stage.sv
// Self-checking bench for z_result_stage: directed scenarios plus a randomized
// run against a result-level reference model.
module tb_z_result_stage;
    import z_stage_pkg::*;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'b0000;
    logic [31:0] alu_out = 32'd0;
    logic [63:0] alu_out2 = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_is_hi;
    logic        out_last;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        zero_flag;
    logic        neg_flag;
    logic        err;
    logic [1:0]  count;

    int tests = 0;
    int failed = 0;

    z_result_stage #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .alu_out(alu_out), .alu_out2(alu_out2), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_is_hi(out_is_hi),
        .out_last(out_last), .hi_q(hi_q), .lo_q(lo_q), .zero_flag(zero_flag),
        .neg_flag(neg_flag), .err(err), .count(count)
    );

    always #5 clock = ~clock;

    task automatic do_clear();
        @(negedge clock);
        clear = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                return;
            end
            @(negedge clock);
        end
    endtask

    task automatic push_one(input logic [3:0] o, input logic [31:0] a, input logic [63:0] a2);
        @(negedge clock);
        in_valid = 1'b1;
        op = o;
        alu_out = a;
        alu_out2 = a2;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        clear = 1'b1;
        #1;
        tests++;
        if ({out_valid, out_data, out_is_hi, out_last, hi_q, lo_q, zero_flag, neg_flag, err, count, in_ready}
            !== {1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1}) begin
            failed++;
            $display("FAIL reset_state: valid=%b data=%h hi=%h lo=%h cnt=%0d rdy=%b err=%b, required all zero, rdy=1",
                     out_valid, out_data, hi_q, lo_q, count, in_ready, err);
        end
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_narrow_add();
        bit ok;
        out_ready = 1'b1;
        push_one(OP_ADD, 32'h0000_0005, 64'd0);
        tests++;
        if (out_valid !== 1'b0) begin
            failed++;
            $display("FAIL add_latency: out_valid=%b one cycle after accept, required 0", out_valid);
        end
        wait_out(ok);
        tests++;
        if (!ok || out_data !== 32'h5 || out_is_hi !== 1'b0 || out_last !== 1'b1) begin
            failed++;
            $display("FAIL add_beat: ok=%b data=%h hi=%b last=%b, required 00000005 0 1", ok, out_data, out_is_hi, out_last);
        end
        @(negedge clock);
        tests++;
        if (out_valid !== 1'b0 || hi_q !== 32'd0 || lo_q !== 32'd0 || zero_flag !== 1'b0 || neg_flag !== 1'b0) begin
            failed++;
            $display("FAIL add_retire: valid=%b hi=%h lo=%h z=%b n=%b, required 0 0 0 0 0",
                     out_valid, hi_q, lo_q, zero_flag, neg_flag);
        end
    endtask

    task automatic test_wide_mul();
        bit ok;
        out_ready = 1'b1;
        push_one(OP_MUL, 32'd0, 64'hFFFF_FFFF_FFFF_FFFA);
        wait_out(ok);
        tests++;
        if (!ok || out_data !== 32'hFFFF_FFFA || out_is_hi !== 1'b0 || out_last !== 1'b0) begin
            failed++;
            $display("FAIL mul_lo: ok=%b data=%h hi=%b last=%b, required fffffffa 0 0", ok, out_data, out_is_hi, out_last);
        end
        @(negedge clock);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFFF || out_is_hi !== 1'b1 || out_last !== 1'b1 || hi_q !== 32'd0) begin
            failed++;
            $display("FAIL mul_hi: valid=%b data=%h hi=%b last=%b hi_q=%h, required 1 ffffffff 1 1 0",
                     out_valid, out_data, out_is_hi, out_last, hi_q);
        end
        @(negedge clock);
        tests++;
        if (hi_q !== 32'hFFFF_FFFF || lo_q !== 32'hFFFF_FFFA || neg_flag !== 1'b1 || zero_flag !== 1'b0 || out_valid !== 1'b0) begin
            failed++;
            $display("FAIL mul_retire: hi=%h lo=%h n=%b z=%b valid=%b, required ffffffff fffffffa 1 0 0",
                     hi_q, lo_q, neg_flag, zero_flag, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        logic [31:0] val = 32'd1;
        out_ready = 1'b0;
        @(negedge clock);
        in_valid = 1'b1;
        op = OP_ADD;
        for (int i = 0; i < 2; i++) begin
            alu_out = val;
            tests++;
            if (in_ready !== 1'b1) begin
                failed++;
                $display("FAIL bp_accept%0d: in_ready=%b, required 1", i, in_ready);
            end
            @(negedge clock);
            val = val + 32'd1;
        end
        alu_out = 32'd3;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'd1) begin
                failed++;
                $display("FAIL bp_hold%0d: in_ready=%b valid=%b data=%h, required 0 1 00000001", i, in_ready, out_valid, out_data);
            end
            @(negedge clock);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && got.size() < 3; i++) begin
            if (out_valid) got.push_back(out_data);
            if (in_valid && in_ready) begin
                @(negedge clock);
                in_valid = 1'b0;
            end else begin
                @(negedge clock);
            end
        end
        in_valid = 1'b0;
        tests++;
        if (got.size() != 3 || got[0] !== 32'd1 || got[1] !== 32'd2 || got[2] !== 32'd3) begin
            failed++;
            $display("FAIL bp_order: got %0d beats, required 1,2,3 in order", got.size());
        end
    endtask

    task automatic test_invalid_op();
        out_ready = 1'b1;
        push_one(4'b1100, 32'hDEAD_BEEF, 64'd0);
        tests++;
        if (err !== 1'b1 || count !== 2'd0 || out_valid !== 1'b0) begin
            failed++;
            $display("FAIL invalid_pulse: err=%b count=%0d valid=%b, required 1 0 0", err, count, out_valid);
        end
        @(negedge clock);
        tests++;
        if (err !== 1'b0 || out_valid !== 1'b0 || count !== 2'd0) begin
            failed++;
            $display("FAIL invalid_after: err=%b valid=%b count=%0d, required 0 0 0", err, out_valid, count);
        end
    endtask

    task automatic test_zero_flag();
        bit ok;
        out_ready = 1'b1;
        push_one(OP_SUB, 32'h0000_0000, 64'hFFFF_0000_0000_0001);
        wait_out(ok);
        @(negedge clock);
        tests++;
        if (!ok || zero_flag !== 1'b1 || neg_flag !== 1'b0 || hi_q !== 32'hFFFF_FFFF || lo_q !== 32'hFFFF_FFFA) begin
            failed++;
            $display("FAIL zero_flag: ok=%b z=%b n=%b hi=%h lo=%h, required 1 1 0 ffffffff fffffffa",
                     ok, zero_flag, neg_flag, hi_q, lo_q);
        end
    endtask

    task automatic test_random();
        logic [33:0] beat_q[$];
        logic [64:0] res_q[$];
        logic [33:0] b;
        logic [64:0] r;
        logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
        logic        m_zero = 1'b0, m_neg = 1'b0, err_exp = 1'b0;
        int          occ = 0;
        bit          hs;
        bit          acc;
        do_clear();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tests++;
            if (count !== occ[1:0] || in_ready !== (occ != DEPTH) || err !== err_exp) begin
                failed++;
                $display("FAIL rnd_ctrl@%0d: count=%0d rdy=%b err=%b, required %0d %b %b",
                         cyc, count, in_ready, err, occ, occ != DEPTH, err_exp);
            end
            tests++;
            if (hi_q !== m_hi || lo_q !== m_lo || zero_flag !== m_zero || neg_flag !== m_neg) begin
                failed++;
                $display("FAIL rnd_arch@%0d: hi=%h lo=%h z=%b n=%b, required %h %h %b %b",
                         cyc, hi_q, lo_q, zero_flag, neg_flag, m_hi, m_lo, m_zero, m_neg);
            end
            if (out_valid && beat_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL rnd_spurious@%0d: out_valid=1 with no result pending, required 0", cyc);
            end
            in_valid = (cyc < 1500) && ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 5) == 0) op = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 2) == 0) op = OP_MUL;
            else op = 4'($urandom_range(0, 10));
            alu_out  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            alu_out2 = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
            out_ready = (cyc >= 1500) || ($urandom_range(0, 3) != 0);
            hs  = out_valid && out_ready;
            acc = in_valid && in_ready;
            if (hs && beat_q.size() > 0) begin
                b = beat_q.pop_front();
                tests++;
                if ({out_last, out_is_hi, out_data} !== b) begin
                    failed++;
                    $display("FAIL rnd_beat@%0d: last=%b hi=%b data=%h, required %b %b %h",
                             cyc, out_last, out_is_hi, out_data, b[33], b[32], b[31:0]);
                end
                if (b[33]) begin
                    r = res_q.pop_front();
                    occ--;
                    if (r[64]) begin
                        m_hi = r[63:32];
                        m_lo = r[31:0];
                        m_zero = (r[63:0] == 64'd0);
                        m_neg = r[63];
                    end else begin
                        m_zero = (r[31:0] == 32'd0);
                        m_neg = r[31];
                    end
                end
            end
            err_exp = acc && (op > 4'd10);
            if (acc && op <= 4'd10) begin
                occ++;
                if (op == 4'd3) begin
                    beat_q.push_back({1'b0, 1'b0, alu_out2[31:0]});
                    beat_q.push_back({1'b1, 1'b1, alu_out2[63:32]});
                    res_q.push_back({1'b1, alu_out2});
                end else begin
                    beat_q.push_back({1'b1, 1'b0, alu_out});
                    res_q.push_back({1'b0, 32'd0, alu_out});
                end
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
        tests++;
        if (beat_q.size() != 0 || out_valid !== 1'b0) begin
            failed++;
            $display("FAIL rnd_drain: %0d beats outstanding, valid=%b, required 0 0", beat_q.size(), out_valid);
        end
    endtask

    task automatic test_mid_drain_clear();
        bit ok;
        out_ready = 1'b1;
        push_one(OP_MUL, 32'd0, 64'h1234_5678_9ABC_DEF0);
        wait_out(ok);
        tests++;
        if (!ok || out_data !== 32'h9ABC_DEF0 || out_last !== 1'b0) begin
            failed++;
            $display("FAIL clr_lo: ok=%b data=%h last=%b, required 9abcdef0 0", ok, out_data, out_last);
        end
        @(negedge clock);
        clear = 1'b1;
        #1;
        tests++;
        if ({out_valid, out_data, out_is_hi, out_last, hi_q, lo_q, zero_flag, neg_flag, err, count, in_ready}
            !== {1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1}) begin
            failed++;
            $display("FAIL clr_async: valid=%b data=%h hi=%h lo=%h cnt=%0d rdy=%b, required all zero, rdy=1",
                     out_valid, out_data, hi_q, lo_q, count, in_ready);
        end
        @(negedge clock);
        clear = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (out_valid) ok = 1'b1;
        end
        tests++;
        if (ok || hi_q !== 32'd0) begin
            failed++;
            $display("FAIL clr_no_replay: beat seen=%b hi=%h, required 0 00000000", ok, hi_q);
        end
    endtask

    initial begin
        test_reset();
        test_narrow_add();
        test_wide_mul();
        test_backpressure();
        test_invalid_op();
        test_zero_flag();
        test_random();
        test_mid_drain_clear();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
